// File: rtl/pll_sup_pkg.sv
// Shared types and width helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        StResetPll  = 3'd0,
        StWaitLock  = 3'd1,
        StStabilize = 3'd2,
        StRun       = 3'd3,
        StLost      = 3'd4,
        StFail      = 3'd5
    } pll_state_e;

    typedef struct packed {
        logic pll_rst;
        logic sys_rst;
        logic ready;
        logic fail;
    } sup_out_t;

    // Bits needed to hold the values 0 .. num_vals-1.
    function automatic int unsigned cnt_width(input int unsigned num_vals);
        return (num_vals <= 1) ? 1 : $clog2(num_vals);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic sup_out_t decode_outputs(input pll_state_e st);
        sup_out_t o;
        o.pll_rst = (st == StResetPll) || (st == StFail);
        o.sys_rst = (st != StRun);
        o.ready   = (st == StRun);
        o.fail    = (st == StFail);
        return o;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for asynchronous status inputs; resets to 0.
module pll_lock_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor on the reference clock; gates the downstream system reset.
// Define PLL_LOCK_STATS_EN to implement the saturating lock-loss counter (else loss_cnt = 0).
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 4,
    parameter int unsigned CNT_W               = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             force_relock,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fail,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int unsigned TimerW =
        cnt_width(max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES));
    localparam int unsigned RetryW = cnt_width(MAX_RETRIES + 1);

    localparam logic [TimerW-1:0] RstLast     = TimerW'(PLL_RST_CYCLES - 1);
    localparam logic [TimerW-1:0] StableLast  = TimerW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryLimit  = RetryW'(MAX_RETRIES);

    pll_state_e        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [RetryW-1:0] retry_inc;
    logic              timeout;
    logic              lk_s;
    sup_out_t          out_q, out_d;

    pll_lock_sync #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (lk_s)
    );

    assign retry_inc = retry_q + RetryW'(1);

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            StResetPll: begin
                if (timer_q == RstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (lk_s) begin
                    state_d = StStabilize;
                end else if (timer_q == TimeoutLast) begin
                    timeout = 1'b1;
                    state_d = (retry_inc < RetryLimit) ? StResetPll : StFail;
                end
            end
            StStabilize: begin
                // A dropout here just restarts the wait; it is not a failed attempt.
                if (!lk_s) begin
                    state_d = StWaitLock;
                end else if (timer_q == StableLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!lk_s) state_d = StLost;
            end
            StLost:  state_d = StResetPll;
            StFail:  state_d = StFail;
            default: state_d = StResetPll;
        endcase
        if (force_relock) begin
            state_d = StResetPll;
            timeout = 1'b0;
        end
    end

    // One timer shared by the three timed states; cleared on every state entry.
    always_comb begin
        timer_d = timer_q;
        if ((state_d != state_q) || force_relock) begin
            timer_d = '0;
        end else if ((state_q == StResetPll) || (state_q == StWaitLock) ||
                     (state_q == StStabilize)) begin
            timer_d = timer_q + TimerW'(1);
        end
    end

    always_comb begin
        retry_d = retry_q;
        if (force_relock || (state_d == StRun)) begin
            retry_d = '0;
        end else if (timeout) begin
            retry_d = retry_inc;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    assign out_d = decode_outputs(state_d);

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q       <= StResetPll;
            timer_q       <= '0;
            retry_q       <= '0;
            out_q.pll_rst <= 1'b1;
            out_q.sys_rst <= 1'b1;
            out_q.ready   <= 1'b0;
            out_q.fail    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            out_q   <= out_d;
        end
    end

    assign pll_rst = out_q.pll_rst;
    assign sys_rst = out_q.sys_rst;
    assign ready   = out_q.ready;
    assign fail    = out_q.fail;

`ifdef PLL_LOCK_STATS_EN
    logic             lost_event;
    logic [CNT_W-1:0] loss_q;

    // A same-cycle force_relock wins, so that loss is not counted.
    assign lost_event = (state_q == StRun) && !lk_s && !force_relock;

    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_q <= '0;
        end else if (lost_event && (loss_q != '1)) begin
            loss_q <= loss_q + CNT_W'(1);
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a phase/countdown reference model predicts the
// outputs after every edge; an independent monitor compares them at the falling edge.
module tb_pll_lock_supervisor;

    localparam int unsigned PLL_RST_CYCLES      = 4;
    localparam int unsigned LOCK_STABLE_CYCLES  = 8;
    localparam int unsigned LOCK_TIMEOUT_CYCLES = 32;
    localparam int unsigned MAX_RETRIES         = 2;
    localparam int unsigned CNT_W               = 8;
    localparam int          LossMax             = (1 << CNT_W) - 1;

    logic             refclk = 1'b0;
    logic             rst;
    logic             locked;
    logic             force_relock;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic             fail;
    logic [CNT_W-1:0] loss_cnt;

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (PLL_RST_CYCLES),
        .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
        .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
        .MAX_RETRIES         (MAX_RETRIES),
        .CNT_W               (CNT_W)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .locked       (locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fail         (fail),
        .loss_cnt     (loss_cnt)
    );

    typedef struct packed {
        logic             pll_rst;
        logic             sys_rst;
        logic             ready;
        logic             fail;
        logic [CNT_W-1:0] loss;
    } obs_t;

    typedef enum int {PhReset, PhWait, PhStab, PhRun, PhLost, PhFail} phase_e;

    obs_t   exp_q[$];
    int     chk_cnt  = 0;
    int     pass_cnt = 0;
    int     cyc      = 0;

    // Reference model: phase plus cycles remaining in it, and a 2-deep history of locked.
    phase_e ph;
    int     remain;
    int     retries;
    int     losses;
    bit     hist[2];

    task automatic model_step(input bit r, input bit f, input bit l);
        bit   lk;
        obs_t e;
        if (r) begin
            ph = PhReset; remain = PLL_RST_CYCLES; retries = 0; losses = 0;
            hist[0] = 1'b0; hist[1] = 1'b0;
        end else begin
            lk = hist[0];
            hist[0] = hist[1];
            hist[1] = l;
            if (f) begin
                ph = PhReset; remain = PLL_RST_CYCLES; retries = 0;
            end else begin
                case (ph)
                    PhReset: begin
                        remain--;
                        if (remain == 0) begin ph = PhWait; remain = LOCK_TIMEOUT_CYCLES; end
                    end
                    PhWait: begin
                        if (lk) begin
                            ph = PhStab; remain = LOCK_STABLE_CYCLES;
                        end else begin
                            remain--;
                            if (remain == 0) begin
                                retries++;
                                if (retries < MAX_RETRIES) begin
                                    ph = PhReset; remain = PLL_RST_CYCLES;
                                end else begin
                                    ph = PhFail;
                                end
                            end
                        end
                    end
                    PhStab: begin
                        if (!lk) begin
                            ph = PhWait; remain = LOCK_TIMEOUT_CYCLES;
                        end else begin
                            remain--;
                            if (remain == 0) begin ph = PhRun; retries = 0; end
                        end
                    end
                    PhRun: begin
                        if (!lk) begin
                            ph = PhLost;
                            if (losses < LossMax) losses++;
                        end
                    end
                    PhLost: begin ph = PhReset; remain = PLL_RST_CYCLES; end
                    default: ;
                endcase
            end
        end
        e.pll_rst = (ph == PhReset) || (ph == PhFail);
        e.sys_rst = (ph != PhRun);
        e.ready   = (ph == PhRun);
        e.fail    = (ph == PhFail);
`ifdef PLL_LOCK_STATS_EN
        e.loss    = CNT_W'(losses);
`else
        e.loss    = '0;
`endif
        exp_q.push_back(e);
    endtask

    // Apply inputs for the next edge, then record the model's prediction just after it.
    task automatic drive(input bit r, input bit l, input bit f);
        rst = r; locked = l; force_relock = f;
        @(posedge refclk);
        #1;
        cyc++;
        model_step(r, f, l);
    endtask

    task automatic hold(input bit l, input int n);
        repeat (n) drive(1'b0, l, 1'b0);
    endtask

    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(negedge refclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pll_rst, sys_rst, ready, fail, loss_cnt};
                chk_cnt++;
                if (a === e) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL outputs cyc=%0d act pll_rst=%b sys_rst=%b ready=%b fail=%b loss=%0d exp pll_rst=%b sys_rst=%b ready=%b fail=%b loss=%0d",
                             cyc, a.pll_rst, a.sys_rst, a.ready, a.fail, a.loss,
                             e.pll_rst, e.sys_rst, e.ready, e.fail, e.loss);
                end
            end
        end
    end

    initial begin : stimulus
        bit lv;
        // Reset, then lock at cycle 10 and release.
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        hold(1'b0, 10);
        hold(1'b1, 40);
        // Lose lock in RUN and never regain it: loss, two timed-out attempts, FAIL.
        hold(1'b0, 100);
        // Leave FAIL with force_relock.
        drive(1'b0, 1'b0, 1'b1);
        hold(1'b0, 10);
        // Short lock, dropout, then stable lock.
        hold(1'b1, 5);
        hold(1'b0, 3);
        hold(1'b1, 40);
        // Three-cycle dropout in RUN, then relock.
        hold(1'b0, 3);
        hold(1'b1, 40);
        // Force in RUN together with a dropout.
        drive(1'b0, 1'b0, 1'b1);
        hold(1'b1, 30);
        // Randomised locked segments with occasional force_relock and rst.
        lv = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) lv = ~lv;
            drive(($urandom_range(0, 599) == 0), lv, ($urandom_range(0, 199) == 0));
        end
        // Enough lock-loss events to saturate the counter.
        repeat (3) drive(1'b1, 1'b1, 1'b0);
        hold(1'b1, 30);
        for (int k = 0; k < 260; k++) begin
            hold(1'b0, 1);
            hold(1'b1, 18);
        end
        hold(1'b1, 5);
        @(negedge refclk);
        @(negedge refclk);
        #1;
        chk_cnt++;
        if (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL scoreboard_drain act pending=%0d exp pending=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
